// File: rtl/newspaper_pkg.sv
// Shared types and defaults for the newspaper dispenser: FSM states, item selects
// and the fixed service-order helpers.
package newspaper_pkg;

  localparam int unsigned NickInitDefault = 8;
  localparam int unsigned DimeInitDefault = 8;
  localparam int unsigned TimeoutDefault  = 15;
  localparam int unsigned CntW            = 4;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFault} state_e;

  typedef enum logic [1:0] {ItemNone, ItemPaper, ItemDime, ItemNick} item_e;

  // Service order is paper, then dimes, then nickels.
  function automatic item_e pick_item(input logic paper, input logic [1:0] dimes,
                                      input logic [2:0] nicks);
    item_e item;
    item = ItemNone;
    if (paper) begin
      item = ItemPaper;
    end else if (dimes != 2'd0) begin
      item = ItemDime;
    end else if (nicks != 3'd0) begin
      item = ItemNick;
    end
    return item;
  endfunction

  // Actuator drive vector {paper, dime, nickel} for an item.
  function automatic logic [2:0] item_eject(input item_e item);
    logic [2:0] vec;
    case (item)
      ItemPaper: vec = 3'b100;
      ItemDime:  vec = 3'b010;
      ItemNick:  vec = 3'b001;
      default:   vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/hopper_timer.sv
// Watchdog for hopper acknowledges: counts cycles while started, flags expiry after
// TIMEOUT consecutive counted cycles.
module hopper_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_start && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expiry is seen on the TIMEOUT-th counted cycle so the FSM leaves on that edge.
  assign o_expired = (r_cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/newspaper_dispenser.sv
// Newspaper vending controller: captures a vend job, sequences paper/dime/nickel
// ejects against hopper acknowledges, tracks inventory and latches hopper timeouts.
module newspaper_dispenser
  import newspaper_pkg::*;
#(
  parameter int unsigned NICK_INIT = NickInitDefault,
  parameter int unsigned DIME_INIT = DimeInitDefault,
  parameter int unsigned TIMEOUT   = TimeoutDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            R,
  input  logic            N1,
  input  logic            D1,
  input  logic            D2,
  input  logic            refill,
  input  logic            coin_done,
  output logic            paper_eject,
  output logic            nick_eject,
  output logic            dime_eject,
  output logic            busy,
  output logic [CntW-1:0] nick_cnt,
  output logic [CntW-1:0] dime_cnt,
  output logic            short_err,
  output logic            overrun,
  output logic            fault
);

  state_e          r_state;
  item_e           r_item;
  logic            r_paper;
  logic [1:0]      r_dimes;
  logic [2:0]      r_nicks;
  logic [CntW-1:0] r_nick_cnt;
  logic [CntW-1:0] r_dime_cnt;
  logic            r_paper_eject;
  logic            r_nick_eject;
  logic            r_dime_eject;
  logic            r_short_err;
  logic            r_overrun;
  logic            r_fault;

  logic            w_cmd;
  logic [CntW-1:0] w_nick_avail;
  logic [CntW-1:0] w_dime_avail;
  logic [1:0]      w_dime_req;
  logic [1:0]      w_dime_job;
  logic [CntW-1:0] w_nick_need;
  logic            w_short;
  logic [1:0]      w_cap_dimes;
  logic [2:0]      w_cap_nicks;
  item_e           w_cap_item;
  logic            w_paper_nx;
  logic [1:0]      w_dimes_nx;
  logic [2:0]      w_nicks_nx;
  item_e           w_next_item;
  logic            w_timer_start;
  logic            w_timer_clear;
  logic            w_timer_expired;

  assign w_cmd = R | N1 | D1 | D2;

  // Refill in the same cycle as a vend is applied first, so capture sees fresh counts.
  always_comb begin
    w_nick_avail = refill ? CntW'(NICK_INIT) : r_nick_cnt;
    w_dime_avail = refill ? CntW'(DIME_INIT) : r_dime_cnt;
    w_dime_req   = D2 ? 2'd2 : (D1 ? 2'd1 : 2'd0);
    w_dime_job   = ({2'b00, w_dime_req} > w_dime_avail) ? w_dime_avail[1:0] : w_dime_req;
    w_nick_need  = {3'b000, N1} + {1'b0, w_dime_req - w_dime_job, 1'b0};
    w_short      = (w_nick_need > w_nick_avail);
    w_cap_dimes  = w_short ? 2'd0 : w_dime_job;
    w_cap_nicks  = w_short ? 3'd0 : w_nick_need[2:0];
    w_cap_item   = pick_item(R, w_cap_dimes, w_cap_nicks);
  end

  always_comb begin
    w_paper_nx = r_paper;
    w_dimes_nx = r_dimes;
    w_nicks_nx = r_nicks;
    case (r_item)
      ItemPaper: w_paper_nx = 1'b0;
      ItemDime:  w_dimes_nx = r_dimes - 2'd1;
      ItemNick:  w_nicks_nx = r_nicks - 3'd1;
      default:   ;
    endcase
    w_next_item = pick_item(w_paper_nx, w_dimes_nx, w_nicks_nx);
  end

  assign w_timer_start = (r_state == StWait) && !coin_done;
  assign w_timer_clear = (r_state != StWait) || coin_done;

  hopper_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_hopper_timer (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (w_timer_start),
    .i_clear  (w_timer_clear),
    .o_expired(w_timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_item        <= ItemNone;
      r_paper       <= 1'b0;
      r_dimes       <= 2'd0;
      r_nicks       <= 3'd0;
      r_nick_cnt    <= CntW'(NICK_INIT);
      r_dime_cnt    <= CntW'(DIME_INIT);
      r_paper_eject <= 1'b0;
      r_nick_eject  <= 1'b0;
      r_dime_eject  <= 1'b0;
      r_short_err   <= 1'b0;
      r_overrun     <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      {r_paper_eject, r_dime_eject, r_nick_eject} <= 3'b000;
      r_short_err <= 1'b0;
      r_overrun   <= w_cmd && (r_state != StIdle);
      unique case (r_state)
        StIdle: begin
          if (refill) begin
            r_nick_cnt <= CntW'(NICK_INIT);
            r_dime_cnt <= CntW'(DIME_INIT);
          end
          if (w_cmd) begin
            r_paper     <= R;
            r_dimes     <= w_cap_dimes;
            r_nicks     <= w_cap_nicks;
            r_item      <= w_cap_item;
            r_short_err <= w_short;
            {r_paper_eject, r_dime_eject, r_nick_eject} <= item_eject(w_cap_item);
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          r_state <= (r_item == ItemNone) ? StIdle : StWait;
        end
        StWait: begin
          if (coin_done) begin
            r_paper <= w_paper_nx;
            r_dimes <= w_dimes_nx;
            r_nicks <= w_nicks_nx;
            r_item  <= w_next_item;
            if (r_item == ItemDime && r_dime_cnt != '0) begin
              r_dime_cnt <= r_dime_cnt - CntW'(1);
            end
            if (r_item == ItemNick && r_nick_cnt != '0) begin
              r_nick_cnt <= r_nick_cnt - CntW'(1);
            end
            if (w_next_item == ItemNone) begin
              r_state <= StIdle;
            end else begin
              {r_paper_eject, r_dime_eject, r_nick_eject} <= item_eject(w_next_item);
              r_state <= StIssue;
            end
          end else if (w_timer_expired) begin
            r_fault <= 1'b1;
            r_state <= StFault;
          end
        end
        StFault: begin
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign paper_eject = r_paper_eject;
  assign nick_eject  = r_nick_eject;
  assign dime_eject  = r_dime_eject;
  assign busy        = (r_state != StIdle);
  assign nick_cnt    = r_nick_cnt;
  assign dime_cnt    = r_dime_cnt;
  assign short_err   = r_short_err;
  assign overrun     = r_overrun;
  assign fault       = r_fault;

endmodule

// File: tb/tb_newspaper_dispenser.sv
// Directed self-checking bench for newspaper_dispenser; outputs sampled 1ns after
// each rising edge, eject vectors compared as {paper, dime, nickel}.
module tb_newspaper_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       R, N1, D1, D2, refill, coin_done;
  logic       paper_eject, nick_eject, dime_eject, busy, short_err, overrun, fault;
  logic [3:0] nick_cnt, dime_cnt;
  logic [2:0] ej;

  int checks = 0;
  int errors = 0;
  int np, nd, nn, ns;

  always #5 clk = ~clk;

  assign ej = {paper_eject, dime_eject, nick_eject};

  newspaper_dispenser dut (
    .clk        (clk),
    .reset      (reset),
    .R          (R),
    .N1         (N1),
    .D1         (D1),
    .D2         (D2),
    .refill     (refill),
    .coin_done  (coin_done),
    .paper_eject(paper_eject),
    .nick_eject (nick_eject),
    .dime_eject (dime_eject),
    .busy       (busy),
    .nick_cnt   (nick_cnt),
    .dime_cnt   (dime_cnt),
    .short_err  (short_err),
    .overrun    (overrun),
    .fault      (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic vend(input logic r, input logic n1, input logic d1, input logic d2,
                      input logic rf);
    R = r; N1 = n1; D1 = d1; D2 = d2; refill = rf;
    tick();
    {R, N1, D1, D2, refill} = 5'b0;
  endtask

  task automatic done();
    coin_done = 1'b1;
    tick();
    coin_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Starts in ISSUE; tallies ejects per item and any eject seen while waiting.
  task automatic serve(input int n, output int p, output int d, output int k,
                       output int stray);
    p = 0; d = 0; k = 0; stray = 0;
    for (int i = 0; i < n; i++) begin
      p += int'(paper_eject);
      d += int'(dime_eject);
      k += int'(nick_eject);
      tick();
      stray += int'(paper_eject) + int'(dime_eject) + int'(nick_eject);
      done();
    end
  endtask

  initial begin
    {R, N1, D1, D2, refill, coin_done} = 6'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_nick", 8'(nick_cnt), 8'd8);
    chk("rst_dime", 8'(dime_cnt), 8'd8);
    chk("rst_ej", 8'(ej), 8'd0);
    chk("rst_flags", 8'({short_err, overrun, fault}), 8'd0);

    // Two-dime return
    vend(0, 0, 0, 1, 0);
    chk("d2_ej1", 8'(ej), 8'b010);
    chk("d2_busy", 8'(busy), 8'd1);
    tick();
    chk("d2_wait", 8'(ej), 8'd0);
    done();
    chk("d2_ej2", 8'(ej), 8'b010);
    chk("d2_cnt7", 8'(dime_cnt), 8'd7);
    tick();
    done();
    chk("d2_idle", 8'(busy), 8'd0);
    chk("d2_cnt6", 8'(dime_cnt), 8'd6);

    // Paper, dime, nickel ordering
    do_reset();
    vend(1, 1, 1, 0, 0);
    chk("rdn_paper", 8'(ej), 8'b100);
    tick();
    tick();
    chk("rdn_hold", 8'(ej), 8'd0);
    done();
    chk("rdn_dime", 8'(ej), 8'b010);
    tick();
    done();
    chk("rdn_nick", 8'(ej), 8'b001);
    chk("rdn_dcnt", 8'(dime_cnt), 8'd7);
    tick();
    done();
    chk("rdn_idle", 8'(busy), 8'd0);
    chk("rdn_ncnt", 8'(nick_cnt), 8'd7);
    chk("rdn_dcnt2", 8'(dime_cnt), 8'd7);

    // Drain dimes, then nickels substitute
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vend(0, 0, 0, 1, 0);
      serve(2, np, nd, nn, ns);
    end
    chk("drain_dime", 8'(dime_cnt), 8'd0);
    chk("drain_nick", 8'(nick_cnt), 8'd8);
    vend(0, 0, 0, 1, 0);
    serve(4, np, nd, nn, ns);
    chk("sub_nn", 8'(nn), 8'd4);
    chk("sub_nd", 8'(nd + np), 8'd0);
    chk("sub_stray", 8'(ns), 8'd0);
    chk("sub_ncnt", 8'(nick_cnt), 8'd4);
    chk("sub_idle", 8'(busy), 8'd0);

    // Shortfall cases with nick_cnt=1, dime_cnt=0
    for (int i = 0; i < 3; i++) begin
      vend(0, 1, 0, 0, 0);
      serve(1, np, nd, nn, ns);
    end
    chk("n1_ncnt", 8'(nick_cnt), 8'd1);
    vend(0, 0, 1, 0, 0);
    chk("empty_short", 8'(short_err), 8'd1);
    chk("empty_ej", 8'(ej), 8'd0);
    chk("empty_busy", 8'(busy), 8'd1);
    tick();
    chk("empty_idle", 8'(busy), 8'd0);
    chk("empty_pulse", 8'(short_err), 8'd0);
    vend(1, 0, 1, 0, 0);
    chk("short_err", 8'(short_err), 8'd1);
    chk("short_paper", 8'(ej), 8'b100);
    serve(1, np, nd, nn, ns);
    chk("short_np", 8'(np), 8'd1);
    chk("short_coins", 8'(nd + nn + ns), 8'd0);
    chk("short_cnts", 8'({nick_cnt, dime_cnt}), 8'h10);

    // Refill together with vend uses refilled counts
    vend(0, 0, 0, 1, 1);
    chk("rf_ej", 8'(ej), 8'b010);
    chk("rf_short", 8'(short_err), 8'd0);
    chk("rf_cnts", 8'({nick_cnt, dime_cnt}), 8'h88);
    serve(2, np, nd, nn, ns);
    chk("rf_nd", 8'(nd), 8'd2);
    chk("rf_dcnt", 8'(dime_cnt), 8'd6);

    // Hopper timeout into FAULT
    do_reset();
    vend(1, 0, 0, 0, 0);
    chk("to_paper", 8'(ej), 8'b100);
    repeat (15) tick();
    chk("to_nofault", 8'(fault), 8'd0);
    chk("to_busy", 8'(busy), 8'd1);
    tick();
    chk("to_fault", 8'(fault), 8'd1);
    chk("to_ej", 8'(ej), 8'd0);
    done();
    chk("to_ignore", 8'({fault, busy, ej}), 8'b11000);
    vend(1, 0, 0, 0, 0);
    chk("to_overrun", 8'(overrun), 8'd1);
    chk("to_ej2", 8'(ej), 8'd0);
    tick();
    chk("to_ovr_pulse", 8'({overrun, fault}), 8'b01);
    do_reset();
    chk("to_rst", 8'({busy, fault}), 8'd0);
    chk("to_rst_cnts", 8'({nick_cnt, dime_cnt}), 8'h88);

    // Overrun in WAIT, then reset mid-job
    vend(1, 0, 0, 0, 0);
    tick();
    vend(0, 1, 0, 0, 0);
    chk("ow_overrun", 8'(overrun), 8'd1);
    chk("ow_ej", 8'(ej), 8'd0);
    tick();
    chk("ow_pulse", 8'({overrun, ej}), 8'd0);
    do_reset();
    chk("ow_rst_busy", 8'(busy), 8'd0);
    chk("ow_rst_ej", 8'(ej), 8'd0);
    done();
    chk("idle_done", 8'({busy, ej}), 8'd0);
    chk("idle_cnts", 8'({nick_cnt, dime_cnt}), 8'h88);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
